// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Single issue slot feeds the ALU; results land in per-requester response buffers.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
);

  logic             iss_valid;
  logic             iss_id;
  logic [3:0]       iss_opcode;
  logic [WIDTH-1:0] iss_op1;
  logic [WIDTH-1:0] iss_op2;
  logic             last_grant;

  logic             rsp0_free;
  logic             rsp1_free;
  logic             drain;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             legal;
  logic             load0;
  logic             load1;
  logic [WIDTH-1:0] load_res;
  logic             load_zero;

  assign rsp0_free = !rsp0_valid || rsp0_ready;
  assign rsp1_free = !rsp1_valid || rsp1_ready;
  assign drain     = iss_valid && (iss_id ? rsp1_free : rsp0_free);
  assign slot_free = !iss_valid || drain;

  // On a tie the requester that did not win last time gets the slot.
  assign grant0 = slot_free && req0_valid && (!req1_valid || last_grant);
  assign grant1 = slot_free && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_opcode = iss_opcode;
  assign alu_op1    = iss_op1;
  assign alu_op2    = iss_op2;

  assign legal     = (32'(iss_opcode) < NUM_OPS);
  assign load_res  = legal ? alu_res : '0;
  assign load_zero = legal ? alu_zero : 1'b1;
  assign load0     = drain && !iss_id;
  assign load1     = drain && iss_id;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iss_valid  <= 1'b0;
      iss_id     <= 1'b0;
      iss_opcode <= '0;
      iss_op1    <= '0;
      iss_op2    <= '0;
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      iss_valid  <= 1'b1;
      iss_id     <= grant1;
      iss_opcode <= grant1 ? req1_opcode : req0_opcode;
      iss_op1    <= grant1 ? req1_op1 : req0_op1;
      iss_op2    <= grant1 ? req1_op2 : req0_op2;
      last_grant <= grant1;
    end else if (drain) begin
      iss_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp0_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp0_zero  <= 1'b0;
      rsp0_err   <= 1'b0;
    end else if (load0) begin
      rsp0_valid <= 1'b1;
      rsp0_res   <= load_res;
      rsp0_zero  <= load_zero;
      rsp0_err   <= !legal;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp1_valid <= 1'b0;
      rsp1_res   <= '0;
      rsp1_zero  <= 1'b0;
      rsp1_err   <= 1'b0;
    end else if (load1) begin
      rsp1_valid <= 1'b1;
      rsp1_res   <= load_res;
      rsp1_zero  <= load_zero;
      rsp1_err   <= !legal;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode = 0, req1_opcode = 0;
  logic [31:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1, rsp1_ready = 1;
  logic [31:0] rsp0_res, rsp1_res;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_op1, alu_op2, alu_res;
  logic        alu_zero;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(32), .NUM_OPS(10)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_zero(alu_zero)
  );

  // Opcodes: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLTU 7 SLL 8 SRL 9 SRA
  always_comb begin
    alu_res = 32'h0;
    case (alu_opcode)
      4'd0: alu_res = alu_op1 + alu_op2;
      4'd1: alu_res = alu_op1 - alu_op2;
      4'd2: alu_res = alu_op1 & alu_op2;
      4'd3: alu_res = alu_op1 | alu_op2;
      4'd4: alu_res = alu_op1 ^ alu_op2;
      4'd5: alu_res = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
      4'd6: alu_res = {31'b0, alu_op1 < alu_op2};
      4'd7: alu_res = alu_op1 << alu_op2[4:0];
      4'd8: alu_res = alu_op1 >> alu_op2[4:0];
      4'd9: alu_res = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_res == 32'h0);

  typedef struct packed {
    logic        who;
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.who) begin
      req1_valid = 1; req1_opcode = v.opc; req1_op1 = v.a; req1_op2 = v.b;
    end else begin
      req0_valid = 1; req0_opcode = v.opc; req0_op1 = v.a; req0_op2 = v.b;
    end
    #1;
    chk("vec_ready", {31'b0, v.who ? req1_ready : req0_ready}, 32'd1);
    chk("vec_other_ready", {31'b0, v.who ? req0_ready : req1_ready}, 32'd0);
    step();
    req0_valid = 0; req1_valid = 0;
    chk("vec_issue_opcode", {28'b0, alu_opcode}, {28'b0, v.opc});
    step();
    chk("vec_rsp_valid", {31'b0, v.who ? rsp1_valid : rsp0_valid}, 32'd1);
    chk("vec_rsp_res", v.who ? rsp1_res : rsp0_res, v.res);
    chk("vec_rsp_zero", {31'b0, v.who ? rsp1_zero : rsp0_zero}, {31'b0, v.zero});
    chk("vec_rsp_err", {31'b0, v.who ? rsp1_err : rsp0_err}, {31'b0, v.err});
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd1,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'd3,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd2,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd12, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'd0,  32'h0000_0002, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd6,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd9,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd10, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 4'd15, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};

    // Reset state
    #2;
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_res", rsp0_res, 32'd0);
    chk("rst_rsp1_err", {31'b0, rsp1_err}, 32'd0);
    chk("rst_alu_opcode", {28'b0, alu_opcode}, 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    #10;
    RST = 0;
    step();

    // Contention: tie right after reset starts with req0, then alternates
    req0_opcode = 4'd1; req0_op1 = 32'd7;  req0_op2 = 32'd7;
    req1_opcode = 4'd3; req1_op1 = 32'hF0; req1_op2 = 32'h0F;
    for (int k = 0; k < 6; k++) begin
      req0_valid = (k < 4); req1_valid = (k < 4);
      #1;
      if (k < 4) begin
        chk("cont_req0_ready", {31'b0, req0_ready}, {31'b0, (k % 2) == 0});
        chk("cont_req1_ready", {31'b0, req1_ready}, {31'b0, (k % 2) == 1});
      end
      if (k < 2) begin
        chk("cont_rsp0_idle", {31'b0, rsp0_valid}, 32'd0);
        chk("cont_rsp1_idle", {31'b0, rsp1_valid}, 32'd0);
      end else if ((k % 2) == 0) begin
        chk("cont_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
        chk("cont_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("cont_rsp0_res", rsp0_res, 32'd0);
        chk("cont_rsp0_zero", {31'b0, rsp0_zero}, 32'd1);
      end else begin
        chk("cont_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
        chk("cont_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("cont_rsp1_res", rsp1_res, 32'h0000_00FF);
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // Single-op vectors, response side always ready
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);
    step();
    step();

    // Backpressure on requester 1
    rsp1_ready = 0;
    req1_valid = 1; req1_opcode = 4'd4; req1_op1 = 32'hAAAA_AAAA; req1_op2 = 32'h5555_5555;
    #1;
    chk("bp_first_ready", {31'b0, req1_ready}, 32'd1);
    step();
    req1_opcode = 4'd5; req1_op1 = 32'hFFFF_FFFF; req1_op2 = 32'h0000_0001;
    #1;
    chk("bp_second_ready", {31'b0, req1_ready}, 32'd1);
    step();
    req1_valid = 0;
    req0_valid = 1; req0_opcode = 4'd0; req0_op1 = 32'd1; req0_op2 = 32'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("bp_rsp1_res_held", rsp1_res, 32'hFFFF_FFFF);
      chk("bp_req0_blocked", {31'b0, req0_ready}, 32'd0);
      chk("bp_req1_blocked", {31'b0, req1_ready}, 32'd0);
      chk("bp_issue_waits", {28'b0, alu_opcode}, 32'd5);
      step();
    end
    req0_valid = 0;
    rsp1_ready = 1;
    step();
    chk("bp_release_valid", {31'b0, rsp1_valid}, 32'd1);
    chk("bp_release_res", rsp1_res, 32'd1);
    chk("bp_release_zero", {31'b0, rsp1_zero}, 32'd0);
    step();
    chk("bp_consumed_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("bp_consumed_hold", rsp1_res, 32'd1);

    // Reset with an operation in the issue stage
    req1_valid = 1; req1_opcode = 4'd9; req1_op1 = 32'h8000_0000; req1_op2 = 32'd4;
    #1;
    chk("mid_rst_accept", {31'b0, req1_ready}, 32'd1);
    step();
    req1_valid = 0;
    chk("mid_rst_issued", {28'b0, alu_opcode}, 32'd9);
    #1;
    RST = 1;
    #1;
    chk("mid_rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("mid_rst_alu_opcode", {28'b0, alu_opcode}, 32'd0);
    chk("mid_rst_alu_op1", alu_op1, 32'd0);
    chk("mid_rst_alu_op2", alu_op2, 32'd0);
    step();
    RST = 0;
    step();
    chk("mid_rst_no_rsp", {31'b0, rsp1_valid}, 32'd0);
    req0_valid = 1; req0_opcode = 4'd0; req0_op1 = 32'd0; req0_op2 = 32'd0;
    req1_valid = 1; req1_opcode = 4'd0; req1_op1 = 32'd0; req1_op2 = 32'd0;
    #1;
    chk("mid_rst_tie_req0", {31'b0, req0_ready}, 32'd1);
    chk("mid_rst_tie_req1", {31'b0, req1_ready}, 32'd0);
    step();
    req0_valid = 0; req1_valid = 0;
    step(); step(); step(); step();

    // Back-to-back SLL on requester 0
    req0_opcode = 4'd7; req0_op1 = 32'd1;
    for (int k = 0; k < 10; k++) begin
      req0_valid = (k < 8);
      req0_op2 = 32'(k);
      #1;
      if (k < 8) chk("b2b_ready", {31'b0, req0_ready}, 32'd1);
      if (k >= 2) begin
        chk("b2b_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
        chk("b2b_rsp_res", rsp0_res, 32'd1 << (k - 2));
      end
      step();
    end
    req0_valid = 0;
    step();
    chk("b2b_drained", {31'b0, rsp0_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
